dmem_arbiter: RTL and testbench

//  Shares the single 256x64 data-memory block between the host (PCI/register

---
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the host register path and
// the CPU MEM stage. One access is granted per cycle (combinationally), the host
// wins contention for at most HOST_BURST consecutive cycles, and a tag pipeline
// matching the RAM read latency steers read data back to whoever issued it.
module dmem_arbiter #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned WDATA_W    = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned HOST_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    // Host (register / PCI) side
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [WDATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,

    // Pipeline MEM-stage side
    input  logic              pipe_req,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [WDATA_W-1:0] pipe_wdata,
    output logic              pipe_stall,
    output logic              pipe_rvalid,
    output logic [DATA_W-1:0] pipe_rdata,

    // RAM side
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int unsigned CNT_W = $clog2(HOST_BURST + 1);
    localparam logic [CNT_W-1:0] BurstMax = CNT_W'(HOST_BURST);

    logic                host_win;
    logic                pipe_win;
    logic [CNT_W-1:0]    burst_cnt_q;
    logic [CNT_W-1:0]    burst_cnt_d;
    logic                rd_push;
    logic [WDATA_W-1:0]  win_wdata;

    // Tag pipeline: valid bit plus owner (1 = host, 0 = pipe) per RAM latency stage
    logic [RD_LAT-1:0]   tag_vld_q;
    logic [RD_LAT-1:0]   tag_vld_d;
    logic [RD_LAT-1:0]   tag_own_q;
    logic [RD_LAT-1:0]   tag_own_d;

    // Grant decision; nothing is granted while reset is asserted
    always_comb begin
        host_win = 1'b0;
        pipe_win = 1'b0;
        if (rst_n) begin
            if (host_req && !(pipe_req && (burst_cnt_q == BurstMax))) begin
                host_win = 1'b1;
            end else if (pipe_req) begin
                pipe_win = 1'b1;
            end
        end
    end

    // Burst counter: counts host grants the pipe had to wait for, saturating
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (!pipe_req || pipe_win) begin
            burst_cnt_d = '0;
        end else if (host_win && (burst_cnt_q != BurstMax)) begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
    end

    // RAM drive from the winner; idle parks the address on the pipe address
    always_comb begin
        win_wdata = host_win ? host_wdata : pipe_wdata;
        ram_addr  = host_win ? host_addr : pipe_addr;
        ram_we    = host_win ? host_we : (pipe_win & pipe_we);
        ram_din   = DATA_W'(win_wdata);
        host_gnt  = host_win;
        pipe_stall = rst_n & pipe_req & ~pipe_win;
        rd_push   = (host_win & ~host_we) | (pipe_win & ~pipe_we);
    end

    // Tag shift: a granted read enters stage 0, the tail lines up with RAM data
    always_comb begin
        tag_vld_d    = '0;
        tag_own_d    = '0;
        tag_vld_d[0] = rd_push;
        tag_own_d[0] = rd_push & host_win;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_own_d[i] = tag_own_q[i-1];
        end
    end

    // State registers; reset drops all in-flight reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt_q <= '0;
            tag_vld_q   <= '0;
            tag_own_q   <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            tag_vld_q   <= tag_vld_d;
            tag_own_q   <= tag_own_d;
        end
    end

    // Read return: both data ports see RAM output, rvalid selects the owner
    always_comb begin
        host_rvalid = tag_vld_q[RD_LAT-1] & tag_own_q[RD_LAT-1];
        pipe_rvalid = tag_vld_q[RD_LAT-1] & ~tag_own_q[RD_LAT-1];
        host_rdata  = ram_dout;
        pipe_rdata  = ram_dout;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (RAM read latency 1 and 2) share the
// same stimulus, each with its own behavioural RAM. Expected read returns are
// queued when a read is driven and checked when the due cycle arrives.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        host_req, host_we, pipe_req, pipe_we;
    logic [7:0]  host_addr, pipe_addr;
    logic [31:0] host_wdata, pipe_wdata;

    logic        u1_host_gnt, u1_host_rvalid, u1_pipe_stall, u1_pipe_rvalid, u1_ram_we;
    logic [63:0] u1_host_rdata, u1_pipe_rdata, u1_ram_din, u1_ram_dout;
    logic [7:0]  u1_ram_addr;
    logic        u2_host_gnt, u2_host_rvalid, u2_pipe_stall, u2_pipe_rvalid, u2_ram_we;
    logic [63:0] u2_host_rdata, u2_pipe_rdata, u2_ram_din, u2_ram_dout;
    logic [7:0]  u2_ram_addr;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        logic        host;
        logic [63:0] data;
        int          due;
    } exp_t;
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter #(.RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(u1_host_gnt), .host_rvalid(u1_host_rvalid),
        .host_rdata(u1_host_rdata),
        .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr),
        .pipe_wdata(pipe_wdata), .pipe_stall(u1_pipe_stall), .pipe_rvalid(u1_pipe_rvalid),
        .pipe_rdata(u1_pipe_rdata),
        .ram_addr(u1_ram_addr), .ram_din(u1_ram_din), .ram_we(u1_ram_we),
        .ram_dout(u1_ram_dout)
    );

    dmem_arbiter #(.RD_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(u2_host_gnt), .host_rvalid(u2_host_rvalid),
        .host_rdata(u2_host_rdata),
        .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr),
        .pipe_wdata(pipe_wdata), .pipe_stall(u2_pipe_stall), .pipe_rvalid(u2_pipe_rvalid),
        .pipe_rdata(u2_pipe_rdata),
        .ram_addr(u2_ram_addr), .ram_din(u2_ram_din), .ram_we(u2_ram_we),
        .ram_dout(u2_ram_dout)
    );

    // Behavioural RAMs: write at the edge, read data RD_LAT edges after address
    logic [63:0] mem1 [256];
    logic [63:0] mem2 [256];
    logic [63:0] rd2a;
    always @(posedge clk) begin
        u1_ram_dout <= mem1[u1_ram_addr];
        if (u1_ram_we) mem1[u1_ram_addr] <= u1_ram_din;
        rd2a        <= mem2[u2_ram_addr];
        u2_ram_dout <= rd2a;
        if (u2_ram_we) mem2[u2_ram_addr] <= u2_ram_din;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Read-return monitor for both instances
    logic eh1, ep1, eh2, ep2;
    always @(negedge clk) begin
        eh1 = 1'b0; ep1 = 1'b0; eh2 = 1'b0; ep2 = 1'b0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            eh1 = q1[0].host; ep1 = !q1[0].host;
        end
        if (q2.size() > 0 && q2[0].due == cyc) begin
            eh2 = q2[0].host; ep2 = !q2[0].host;
        end
        check("u1_host_rvalid", u1_host_rvalid, eh1);
        check("u1_pipe_rvalid", u1_pipe_rvalid, ep1);
        check("u2_host_rvalid", u2_host_rvalid, eh2);
        check("u2_pipe_rvalid", u2_pipe_rvalid, ep2);
        if (eh1 || ep1) begin
            check("u1_rdata", q1[0].host ? u1_host_rdata : u1_pipe_rdata, q1[0].data);
            void'(q1.pop_front());
        end
        if (eh2 || ep2) begin
            check("u2_rdata", q2[0].host ? u2_host_rdata : u2_pipe_rdata, q2[0].data);
            void'(q2.pop_front());
        end
    end

    task automatic drive(input logic hr, input logic hw, input logic [7:0] ha,
                         input logic [31:0] hd, input logic pr, input logic pw,
                         input logic [7:0] pa, input logic [31:0] pd);
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
        pipe_req = pr; pipe_we = pw; pipe_addr = pa; pipe_wdata = pd;
    endtask

    // One cycle: check grant and RAM drive, queue the read return if tracked
    task automatic step(input string tag, input logic eh, input logic ep,
                        input logic [63:0] rd_exp, input bit trk);
        logic        we_e;
        logic [7:0]  a_e;
        logic [63:0] d_e;
        @(negedge clk);
        we_e = eh ? host_we : (ep & pipe_we);
        a_e  = eh ? host_addr : pipe_addr;
        d_e  = {32'h0, (eh ? host_wdata : pipe_wdata)};
        check({tag, "_u1_gnt"}, u1_host_gnt, eh);
        check({tag, "_u2_gnt"}, u2_host_gnt, eh);
        check({tag, "_u1_stall"}, u1_pipe_stall, pipe_req & ~ep);
        check({tag, "_u2_stall"}, u2_pipe_stall, pipe_req & ~ep);
        check({tag, "_ram_we"}, u1_ram_we, we_e);
        check({tag, "_ram_addr"}, u1_ram_addr, a_e);
        if (we_e) check({tag, "_ram_din"}, u1_ram_din, d_e);
        if (trk && ((eh && !host_we) || (ep && !pipe_we))) begin
            q1.push_back('{eh, rd_exp, cyc + 1});
            q2.push_back('{eh, rd_exp, cyc + 2});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;

        // 1: reset with random inputs
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 1'($urandom), 8'($urandom), $urandom,
                  1'($urandom), 1'($urandom), 8'($urandom), $urandom);
            @(negedge clk);
            check("rst_host_gnt", u1_host_gnt, 1'b0);
            check("rst_ram_we", u1_ram_we, 1'b0);
            check("rst_pipe_stall", u1_pipe_stall, 1'b0);
            check("rst_u2_ram_we", u2_ram_we, 1'b0);
            @(posedge clk);
            #1;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step("idle0", 0, 0, 0, 1);

        // 2: host write then read back
        drive(1, 1, 8'h10, 32'hDEADBEEF, 0, 0, 8'h00, 0);
        step("t2_wr", 1, 0, 0, 1);
        drive(1, 0, 8'h10, 0, 0, 0, 8'h00, 0);
        step("t2_rd", 1, 0, 64'h0000_0000_DEAD_BEEF, 1);

        // 3: contention for 10 cycles: HHHHPHHHHP
        drive(1, 0, 8'h10, 0, 1, 1, 8'h40, 32'hCAFEF00D);
        for (int i = 0; i < 10; i++) begin
            step($sformatf("t3_%0d", i), (i % 5) != 4, (i % 5) == 4,
                 64'h0000_0000_DEAD_BEEF, 1);
        end
        drive(0, 0, 0, 0, 0, 0, 8'h33, 0);
        step("t3_idle", 0, 0, 0, 1);

        // 4: pipe store then load same address
        drive(0, 0, 0, 0, 1, 1, 8'h22, 32'h12345678);
        step("t4_st", 0, 1, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 8'h22, 0);
        step("t4_ld", 0, 1, 64'h0000_0000_1234_5678, 1);

        // 5: alternating owners back to back
        drive(1, 0, 8'h10, 0, 0, 0, 0, 0);
        step("t5_h0", 1, 0, 64'h0000_0000_DEAD_BEEF, 1);
        drive(0, 0, 0, 0, 1, 0, 8'h22, 0);
        step("t5_p0", 0, 1, 64'h0000_0000_1234_5678, 1);
        drive(1, 0, 8'h22, 0, 0, 0, 0, 0);
        step("t5_h1", 1, 0, 64'h0000_0000_1234_5678, 1);
        drive(0, 0, 0, 0, 1, 0, 8'h40, 0);
        step("t5_p1", 0, 1, 64'h0000_0000_CAFE_F00D, 1);
        drive(1, 0, 8'h40, 0, 0, 0, 0, 0);
        step("t5_h2", 1, 0, 64'h0000_0000_CAFE_F00D, 1);

        // Simultaneous writes: host wins, pipe retries next cycle
        drive(1, 1, 8'h50, 32'h1111, 1, 1, 8'h50, 32'h2222);
        step("tw_both", 1, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 1, 8'h50, 32'h2222);
        step("tw_retry", 0, 1, 0, 1);
        drive(1, 0, 8'h50, 0, 0, 0, 0, 0);
        step("tw_rd", 1, 0, 64'h0000_0000_0000_2222, 1);
        drive(0, 0, 0, 0, 0, 0, 8'h01, 0);
        for (int i = 0; i < 3; i++) step("drain", 0, 0, 0, 1);

        // 6: read granted, reset next cycle -> return is discarded
        drive(1, 0, 8'h10, 0, 0, 0, 0, 0);
        step("t6_rd", 1, 0, 0, 0);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t6_rst_gnt", u1_host_gnt, 1'b0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step("t6_post", 0, 0, 0, 1);

        check("q1_empty", 64'(q1.size()), 64'd0);
        check("q2_empty", 64'(q2.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
